sram_like_arbiter: RTL and testbench

Shares one downstream sram-like memory port between the instruction requester (pre_IF fetch) and the data requester (MEM-stage load/store). Grants one request per cycle, holds the grant stable while a request stalls for `addr_ok`, and records each accepted request's owner in an in-order ID queue. Each returning `data_ok` is routed back to the correct requester. It sits between the CPU core's two sram-like ports and the cache/AXI bridge.

---
 rtl/sram_like_arbiter_pkg.sv | 25 ++
 rtl/sram_like_arbiter_arb_id_fifo.sv | 69 ++++++
 rtl/sram_like_arbiter.sv | 131 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared IDs, default depth and request bundle for the sram-like port arbiter.
// Requester ID encoding: 0 = instruction fetch, 1 = MEM-stage data.
package sram_like_arbiter_pkg;

   localparam logic ARB_ID_INST = 1'b0;
   localparam logic ARB_ID_DATA = 1'b1;
   localparam int   DEFAULT_MAX_OUTSTANDING = 4;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        cached;
   } sram_req_t;

   // Unlocked grant choice; prefer_inst only matters when both requesters contend.
   function automatic logic pick_id(input logic inst_req, input logic data_req,
                                    input logic prefer_inst);
      if (inst_req && data_req) return prefer_inst ? ARB_ID_INST : ARB_ID_DATA;
      return data_req ? ARB_ID_DATA : ARB_ID_INST;
   endfunction

endpackage

// File: rtl/sram_like_arbiter_arb_id_fifo.sv
// arb_id_fifo: 1-bit synchronous FIFO holding the owner ID of each accepted request.
// Pointers wrap modulo DEPTH; count distinguishes full from empty.
module arb_id_fifo
   import sram_like_arbiter_pkg::*;
#(
   parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt_q == CNT_FULL);
   assign empty   = (cnt_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset: an entry is only read after it has been pushed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates one sram-like memory port between inst and data requesters, routing data_ok in order.
// Optional build macro SRAM_ARB_RR_EN: round-robin on contention instead of data-over-inst priority.
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic        inst_cached,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic        data_cached,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic        mem_cached,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   logic      locked_q, locked_d;
   logic      locked_id_q, locked_id_d;
   logic      grant_id, prefer_inst, granted_req;
   logic      push, pop;
   logic      fifo_full, fifo_empty, head_id;
   sram_req_t inst_r, data_r, sel_r;

`ifdef SRAM_ARB_RR_EN
   logic last_grant_q;

   assign prefer_inst = (last_grant_q == ARB_ID_DATA);

   always_ff @(posedge clk) begin
      if (!resetn)   last_grant_q <= ARB_ID_INST;
      else if (push) last_grant_q <= grant_id;
   end
`else
   assign prefer_inst = 1'b0;
`endif

   // A stalled request keeps the port until addr_ok so its fields stay stable downstream.
   assign grant_id    = locked_q ? locked_id_q : pick_id(inst_req, data_req, prefer_inst);
   assign granted_req = (grant_id == ARB_ID_DATA) ? data_req : inst_req;

   assign inst_r = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata, inst_cached};
   assign data_r = {data_wr, data_size, data_wstrb, data_addr, data_wdata, data_cached};
   assign sel_r  = (grant_id == ARB_ID_DATA) ? data_r : inst_r;

   assign mem_req    = granted_req & ~fifo_full & resetn;
   assign mem_wr     = sel_r.wr;
   assign mem_size   = sel_r.size;
   assign mem_wstrb  = sel_r.wstrb;
   assign mem_addr   = sel_r.addr;
   assign mem_wdata  = sel_r.wdata;
   assign mem_cached = sel_r.cached;

   assign push = mem_req & mem_addr_ok;
   assign pop  = mem_data_ok;

   assign inst_addr_ok = push & (grant_id == ARB_ID_INST);
   assign data_addr_ok = push & (grant_id == ARB_ID_DATA);
   assign inst_data_ok = mem_data_ok & ~fifo_empty & (head_id == ARB_ID_INST);
   assign data_data_ok = mem_data_ok & ~fifo_empty & (head_id == ARB_ID_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_comb begin
      locked_d    = locked_q;
      locked_id_d = locked_id_q;
      if (mem_req && !mem_addr_ok) begin
         locked_d    = 1'b1;
         locked_id_d = grant_id;
      end else if (push) begin
         locked_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) locked_q <= 1'b0;
      else         locked_q <= locked_d;
   end

   always_ff @(posedge clk) begin
      locked_id_q <= locked_id_d;
   end

   arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .pop    (pop),
      .din    (grant_id),
      .dout   (head_id),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (resetn && mem_data_ok && fifo_empty)
         $display("sram_like_arbiter: stray mem_data_ok with empty ID queue dropped at %0t", $time);
      if (resetn && locked_q)
         assert (granted_req)
         else $error("sram_like_arbiter: requester withdrew req while its grant was locked");
   end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_sram_like_arbiter;

`ifdef SRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   localparam int MAXO = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, inst_cached, inst_addr_ok, inst_data_ok;
   logic [1:0]  inst_size;
   logic [3:0]  inst_wstrb;
   logic [31:0] inst_addr, inst_wdata, inst_rdata;
   logic        data_req, data_wr, data_cached, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_req, mem_wr, mem_cached, mem_addr_ok, mem_data_ok;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [4:0]  hs;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: owners of accepted requests in issue order, plus the stalled owner.
   int pend[$];
   bit stall_v, stall_id, last_g;
   bit e_grant, e_mem_req, e_iaok, e_daaok, e_idok, e_ddok;

   always #5 clk = ~clk;

   assign hs = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};

   sram_like_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_cached(inst_cached),
      .inst_size(inst_size), .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_cached(data_cached),
      .data_size(data_size), .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_cached(mem_cached), .mem_size(mem_size),
      .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   function automatic void eval_model();
      bit g, greq;
      if (stall_v)                    g = stall_id;
      else if (inst_req && data_req)  g = RR ? !last_g : 1'b1;
      else                            g = data_req;
      greq      = g ? data_req : inst_req;
      e_grant   = g;
      e_mem_req = greq && (pend.size() < MAXO) && resetn;
      e_iaok    = e_mem_req && mem_addr_ok && !g;
      e_daaok   = e_mem_req && mem_addr_ok && g;
      e_idok    = mem_data_ok && (pend.size() > 0) && (pend[0] == 0);
      e_ddok    = mem_data_ok && (pend.size() > 0) && (pend[0] == 1);
   endfunction

   function automatic void advance_model();
      bit acc;
      if (!resetn) begin
         pend.delete();
         stall_v = 0;
         last_g  = 0;
      end else begin
         acc = e_mem_req && mem_addr_ok;
         if (mem_data_ok && pend.size() > 0) void'(pend.pop_front());
         if (acc) pend.push_back(int'(e_grant));
         if (e_mem_req && !mem_addr_ok) begin
            stall_v  = 1;
            stall_id = e_grant;
         end else if (acc) begin
            stall_v = 0;
         end
         if (acc) last_g = e_grant;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      eval_model();
      advance_model();
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      eval_model();
   endtask

   task automatic set_idle();
      inst_req = 0; inst_wr = 0; inst_cached = 1; inst_size = 2'd2; inst_wstrb = 4'hF;
      inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_cached = 1; data_size = 2'd2; data_wstrb = 4'hF;
      data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   task automatic drain();
      inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      for (int k = 0; k < 8 && pend.size() > 0; k++) tick();
      mem_data_ok = 0;
   endtask

   task automatic test_reset();
      resetn = 0; inst_req = 1; data_req = 1; mem_addr_ok = 1;
      tick(); tick();
      mem_data_ok = 1;
      settle();
      n_cmp++;
      if (hs !== 5'b00000) begin
         n_fail++; $display("FAIL reset_hs got %b want %b", hs, 5'b00000);
      end
      tick();
      resetn = 1; set_idle();
      settle();
      n_cmp++;
      if (hs !== 5'b00000) begin
         n_fail++; $display("FAIL reset_idle_hs got %b want %b", hs, 5'b00000);
      end
      tick();
   endtask

   task automatic test_inst_read();
      inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
      settle();
      n_cmp++;
      if (hs !== 5'b11000 || mem_addr !== 32'hBFC0_0000) begin
         n_fail++; $display("FAIL inst_read_c0 got hs=%b addr=%h want 11000 bfc00000", hs, mem_addr);
      end
      tick();
      inst_req = 0; mem_addr_ok = 0;
      settle();
      n_cmp++;
      if (hs !== 5'b00000) begin
         n_fail++; $display("FAIL inst_read_c1 got %b want 00000", hs);
      end
      tick();
      mem_data_ok = 1; mem_rdata = 32'h3C1D_0001;
      settle();
      n_cmp++;
      if (hs !== 5'b00010 || inst_rdata !== 32'h3C1D_0001) begin
         n_fail++; $display("FAIL inst_read_c2 got hs=%b rdata=%h want 00010 3c1d0001", hs, inst_rdata);
      end
      tick();
      mem_data_ok = 0;
   endtask

   task automatic test_contention();
      logic [4:0] want [3];
      inst_req = 1; inst_addr = 32'h0000_1000; data_req = 1; data_addr = 32'h8000_2000;
      mem_addr_ok = 1;
      settle();
      n_cmp++;
      if (hs !== 5'b10100 || mem_addr !== 32'h8000_2000) begin
         n_fail++; $display("FAIL contend_first got hs=%b addr=%h want 10100 80002000", hs, mem_addr);
      end
      tick();
      data_req = 0;
      settle();
      n_cmp++;
      if (hs !== 5'b11000 || mem_addr !== 32'h0000_1000) begin
         n_fail++; $display("FAIL contend_second got hs=%b addr=%h want 11000 00001000", hs, mem_addr);
      end
      tick();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      settle();
      n_cmp++;
      if (hs !== 5'b00001) begin
         n_fail++; $display("FAIL contend_rsp0 got %b want 00001", hs);
      end
      tick();
      settle();
      n_cmp++;
      if (hs !== 5'b00010) begin
         n_fail++; $display("FAIL contend_rsp1 got %b want 00010", hs);
      end
      tick();
      mem_data_ok = 0;
      // Three back-to-back contention cycles.
      want[0] = 5'b10100;
      want[1] = RR ? 5'b11000 : 5'b10100;
      want[2] = 5'b10100;
      inst_req = 1; data_req = 1; mem_addr_ok = 1;
      for (int c = 0; c < 3; c++) begin
         settle();
         n_cmp++;
         if (hs !== want[c]) begin
            n_fail++; $display("FAIL contend3_c%0d got %b want %b", c, hs, want[c]);
         end
         tick();
      end
      drain();
   endtask

   task automatic test_lock();
      inst_req = 1; inst_addr = 32'h1000_0040; data_addr = 32'h2000_0080; mem_addr_ok = 0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) data_req = 1;
         settle();
         n_cmp++;
         if (hs !== 5'b10000 || mem_addr !== 32'h1000_0040) begin
            n_fail++; $display("FAIL lock_stall_c%0d got hs=%b addr=%h want 10000 10000040", c, hs, mem_addr);
         end
         tick();
      end
      mem_addr_ok = 1;
      settle();
      n_cmp++;
      if (hs !== 5'b11000 || mem_addr !== 32'h1000_0040) begin
         n_fail++; $display("FAIL lock_release got hs=%b addr=%h want 11000 10000040", hs, mem_addr);
      end
      tick();
      inst_req = 0;
      settle();
      n_cmp++;
      if (hs !== 5'b10100 || mem_addr !== 32'h2000_0080) begin
         n_fail++; $display("FAIL lock_next got hs=%b addr=%h want 10100 20000080", hs, mem_addr);
      end
      tick();
      drain();
   endtask

   task automatic test_full();
      inst_req = 1; mem_addr_ok = 1;
      for (int c = 0; c < MAXO; c++) begin
         inst_addr = 32'h0000_3000 + 32'(c * 4);
         settle();
         n_cmp++;
         if (hs !== 5'b11000) begin
            n_fail++; $display("FAIL full_fill%0d got %b want 11000", c, hs);
         end
         tick();
      end
      inst_req = 0; data_req = 1; data_addr = 32'h0000_4000; mem_data_ok = 1;
      settle();
      n_cmp++;
      if (hs !== 5'b00010) begin
         n_fail++; $display("FAIL full_blocked got %b want 00010", hs);
      end
      tick();
      mem_data_ok = 0;
      settle();
      n_cmp++;
      if (hs !== 5'b10100) begin
         n_fail++; $display("FAIL full_accept got %b want 10100", hs);
      end
      tick();
      drain();
   endtask

   task automatic test_reset_mid();
      inst_req = 1; mem_addr_ok = 1;
      for (int c = 0; c < 3; c++) tick();
      inst_req = 0; resetn = 0;
      tick();
      resetn = 1; mem_data_ok = 1; mem_addr_ok = 0;
      settle();
      n_cmp++;
      if (hs !== 5'b00000) begin
         n_fail++; $display("FAIL rstmid_stray got %b want 00000", hs);
      end
      tick();
      mem_data_ok = 0; data_req = 1; mem_addr_ok = 1;
      for (int c = 0; c <= MAXO; c++) begin
         settle();
         n_cmp++;
         if (hs !== ((c < MAXO) ? 5'b10100 : 5'b00000)) begin
            n_fail++; $display("FAIL rstmid_issue%0d got %b want %b", c, hs,
                               (c < MAXO) ? 5'b10100 : 5'b00000);
         end
         tick();
      end
      drain();
   endtask

   task automatic test_interleave();
      int ids [4] = '{0, 1, 1, 0};
      int n_i = 0, n_d = 0;
      for (int g = 0; g < 4; g++) begin
         mem_data_ok = 0; mem_addr_ok = 1;
         for (int k = 0; k < 4; k++) begin
            inst_req = (ids[k] == 0); data_req = (ids[k] == 1);
            inst_addr = 32'(g * 16 + k); data_addr = 32'h100 + 32'(g * 16 + k);
            settle();
            n_cmp++;
            if (hs !== (ids[k] ? 5'b10100 : 5'b11000)) begin
               n_fail++; $display("FAIL ilv_issue g%0d k%0d got %b", g, k, hs);
            end
            tick();
         end
         inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
         for (int k = 0; k < 4; k++) begin
            settle();
            if (inst_data_ok === 1'b1) n_i++;
            if (data_data_ok === 1'b1) n_d++;
            n_cmp++;
            if (hs !== (ids[k] ? 5'b00001 : 5'b00010)) begin
               n_fail++; $display("FAIL ilv_rsp g%0d k%0d got %b", g, k, hs);
            end
            tick();
         end
      end
      mem_data_ok = 0;
      n_cmp++;
      if (n_i != 8 || n_d != 8) begin
         n_fail++; $display("FAIL ilv_totals got inst=%0d data=%0d want 8 8", n_i, n_d);
      end
   endtask

   task automatic test_random();
      bit i_act = 0, d_act = 0;
      logic [71:0] exp_f, got_f;
      for (int c = 0; c < 600; c++) begin
         if (!i_act && $urandom_range(0, 2) == 0) begin
            i_act = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom); inst_wstrb = 4'($urandom);
            inst_addr = $urandom; inst_wdata = $urandom; inst_cached = 1'($urandom);
         end
         if (!d_act && $urandom_range(0, 2) == 0) begin
            d_act = 1; data_wr = 1'($urandom); data_size = 2'($urandom); data_wstrb = 4'($urandom);
            data_addr = $urandom; data_wdata = $urandom; data_cached = 1'($urandom);
         end
         inst_req = i_act; data_req = d_act;
         mem_addr_ok = ($urandom_range(0, 3) != 0);
         mem_data_ok = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
         mem_rdata = $urandom;
         settle();
         n_cmp++;
         if (hs !== {e_mem_req, e_iaok, e_daaok, e_idok, e_ddok}) begin
            n_fail++; $display("FAIL rand_hs c%0d got %b want %b", c, hs,
                               {e_mem_req, e_iaok, e_daaok, e_idok, e_ddok});
         end
         if (e_mem_req) begin
            exp_f = e_grant ? {data_wr, data_size, data_wstrb, data_addr, data_wdata, data_cached}
                            : {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata, inst_cached};
            got_f = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata, mem_cached};
            n_cmp++;
            if (got_f !== exp_f) begin
               n_fail++; $display("FAIL rand_fields c%0d got %h want %h", c, got_f, exp_f);
            end
         end
         n_cmp++;
         if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin
            n_fail++; $display("FAIL rand_rdata c%0d got %h/%h want %h", c, inst_rdata, data_rdata, mem_rdata);
         end
         if (e_iaok) i_act = 0;
         if (e_daaok) d_act = 0;
         tick();
      end
      // Finish any stalled request before draining so no req is withdrawn under lock.
      mem_addr_ok = 1; mem_data_ok = 0;
      for (int k = 0; k < 8 && (i_act || d_act); k++) begin
         settle();
         if (e_iaok) i_act = 0;
         if (e_daaok) d_act = 0;
         tick();
         inst_req = i_act; data_req = d_act;
         if (pend.size() >= MAXO) mem_data_ok = 1; else mem_data_ok = 0;
      end
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 0;
      stall_v = 0; stall_id = 0; last_g = 0;
      set_idle();
      test_reset();
      test_inst_read();
      test_contention();
      test_lock();
      test_full();
      test_reset_mid();
      test_interleave();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
